my_adder_unit: RTL and testbench



---
 rtl/my_adder_unit.sv | 65 ++++++
 tb/tb_my_adder_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/my_adder_unit.sv
`default_nettype none
// ============================================================================
// my_adder_unit : ripple full adder slice, combinational sum/carry plus a
//                 registered copy with signed-overflow flag.  Rev 1.0
// ============================================================================
module my_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C_in,
  output logic [WIDTH-1:0] Z,
  output logic             C_out,
  output logic [WIDTH-1:0] Z_r,
  output logic             C_out_r,
  output logic             ovf_r
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = C_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = X[i] ^ Y[i] ^ carry[i];
      carry[i+1] = (X[i] & Y[i]) | (X[i] & carry[i]) | (Y[i] & carry[i]);
    end
  end

  assign Z     = sum;
  assign C_out = carry[WIDTH];

  logic [WIDTH-1:0] z_d, z_q;
  logic             c_out_d, c_out_q;
  logic             ovf_d, ovf_q;

  // Overflow: carry into the MSB disagrees with carry out of it.
  always_comb begin
    z_d     = sum;
    c_out_d = carry[WIDTH];
    ovf_d   = carry[WIDTH-1] ^ carry[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      z_q     <= z_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Z_r     = z_q;
  assign C_out_r = c_out_q;
  assign ovf_r   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_my_adder_unit.sv
`default_nettype none
// ============================================================================
// tb_my_adder_unit : directed self-checking bench for WIDTH=1 and WIDTH=8.
//                    Rev 1.0
// ============================================================================
module tb_my_adder_unit;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst;
  logic       x1, y1, cin1;
  logic       z1, cout1, z1_r, cout1_r, ovf1_r;
  logic [7:0] x8, y8, z8, z8_r;
  logic       cin8, cout8, cout8_r, ovf8_r;

  int n_tests = 0;
  int n_fail  = 0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  my_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .X(x1), .Y(y1), .C_in(cin1),
    .Z(z1), .C_out(cout1), .Z_r(z1_r), .C_out_r(cout1_r), .ovf_r(ovf1_r)
  );

  my_adder_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .X(x8), .Y(y8), .C_in(cin8),
    .Z(z8), .C_out(cout8), .Z_r(z8_r), .C_out_r(cout8_r), .ovf_r(ovf8_r)
  );

  task automatic check(input string tag, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // WIDTH=1 truth table indexed by {C_in,Y,X}
  logic [7:0] tt_z    = 8'b1001_0110;
  logic [7:0] tt_cout = 8'b1110_1000;

  // Mid-stream vectors: x, y, cin, rst, comb Z, comb C_out, registered ovf
  logic [7:0] v_x    [6] = '{8'h12, 8'h80, 8'hF0, 8'h40, 8'hFF, 8'h7F};
  logic [7:0] v_y    [6] = '{8'h34, 8'h80, 8'h0F, 8'h40, 8'hFF, 8'h7F};
  logic       v_cin  [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
  logic       v_rst  [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
  logic [7:0] v_z    [6] = '{8'h46, 8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF};
  logic       v_cout [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
  logic       v_ovf  [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};

  initial begin
    rst = 1'b1;
    x1 = 1'b0; y1 = 1'b0; cin1 = 1'b0;
    x8 = 8'h00; y8 = 8'h00; cin8 = 1'b0;

    // Combinational truth table with the clock idle
    for (int i = 0; i < 8; i++) begin
      {cin1, y1, x1} = 3'(i);
      #1;
      check($sformatf("tt%0d_z", i),    {8'h0, z1},    {8'h0, tt_z[i]});
      check($sformatf("tt%0d_cout", i), {8'h0, cout1}, {8'h0, tt_cout[i]});
    end

    // Reset held for two edges with all-ones inputs
    x1 = 1'b1; y1 = 1'b1; cin1 = 1'b1;
    x8 = 8'hFF; y8 = 8'hFF; cin8 = 1'b1;
    clk_run = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      check($sformatf("rst%0d_z_r", e),    {8'h0, z1_r},    9'h0);
      check($sformatf("rst%0d_cout_r", e), {8'h0, cout1_r}, 9'h0);
      check($sformatf("rst%0d_ovf_r", e),  {8'h0, ovf1_r},  9'h0);
      check($sformatf("rst%0d_z", e),      {8'h0, z1},      9'h1);
      check($sformatf("rst%0d_cout", e),   {8'h0, cout1},   9'h1);
      check($sformatf("rst%0d_z8_r", e),   {1'b0, z8_r},    9'h0);
      check($sformatf("rst%0d_z8", e),     {1'b0, z8},      9'hFF);
      check($sformatf("rst%0d_cout8", e),  {8'h0, cout8},   9'h1);
    end

    // Release reset: first edge loads the current sum
    @(negedge clk);
    rst = 1'b0;
    x1 = 1'b1; y1 = 1'b0; cin1 = 1'b1;
    x8 = 8'hFF; y8 = 8'h00; cin8 = 1'b1;
    #1;
    check("wrap_z8",    {1'b0, z8},    9'h00);
    check("wrap_cout8", {8'h0, cout8}, 9'h1);
    @(posedge clk); #1;
    check("lat_z_r",     {8'h0, z1_r},    9'h0);
    check("lat_cout_r",  {8'h0, cout1_r}, 9'h1);
    check("lat_ovf_r",   {8'h0, ovf1_r},  9'h0);
    check("wrap_z8_r",   {1'b0, z8_r},    9'h00);
    check("wrap_cout8_r",{8'h0, cout8_r}, 9'h1);
    check("wrap_ovf8_r", {8'h0, ovf8_r},  9'h0);

    // Signed overflow
    @(negedge clk);
    x8 = 8'h7F; y8 = 8'h01; cin8 = 1'b0;
    #1;
    check("sovf_z8",    {1'b0, z8},    9'h80);
    check("sovf_cout8", {8'h0, cout8}, 9'h0);
    @(posedge clk); #1;
    check("sovf_z8_r",   {1'b0, z8_r},    9'h80);
    check("sovf_cout8_r",{8'h0, cout8_r}, 9'h0);
    check("sovf_ovf8_r", {8'h0, ovf8_r},  9'h1);

    // Toggling inputs with a single-edge reset pulse
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      x8 = v_x[k]; y8 = v_y[k]; cin8 = v_cin[k]; rst = v_rst[k];
      #1;
      check($sformatf("ms%0d_z8", k),    {1'b0, z8},    {1'b0, v_z[k]});
      check($sformatf("ms%0d_cout8", k), {8'h0, cout8}, {8'h0, v_cout[k]});
      @(posedge clk); #1;
      check($sformatf("ms%0d_z8_r", k),    {1'b0, z8_r},
            v_rst[k] ? 9'h0 : {1'b0, v_z[k]});
      check($sformatf("ms%0d_cout8_r", k), {8'h0, cout8_r},
            v_rst[k] ? 9'h0 : {8'h0, v_cout[k]});
      check($sformatf("ms%0d_ovf8_r", k),  {8'h0, ovf8_r},
            v_rst[k] ? 9'h0 : {8'h0, v_ovf[k]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
